mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback select for the 5-stage pipelined RV32I core.
//  Captures MEM-stage results and formats load data (byte/half/word, sign/zero extend).
//  Drives the register file write port (rd addr/data/wren) and the WB-stage forwarding source.
//  Register file writes on negedge, so ID reads the WB value in the same cycle; no extra bypass here.
// PARAMETERS
//  XLEN        32    datapath width (only 32 supported)
//  INSTRET_W   64    width of retired-instruction counter (used only with WB_INSTRET_EN)
// PORTS
//  i_clk          in   1     global clock, all state updates on posedge
//  i_reset        in   1     asynchronous, active-high reset
//  i_stall        in   1     hold MEM/WB register contents
//  i_flush        in   1     insert bubble into MEM/WB register
//  i_valid        in   1     MEM-stage instruction valid
//  i_pc           in   32    PC of MEM-stage instruction
//  i_alu_data     in   32    ALU result / effective address
//  i_ld_word      in   32    raw aligned word returned by LSU
//  i_ld_size      in   2     00 byte, 01 half, 10 word, 11 reserved
//  i_ld_unsigned  in   1     1 = zero-extend (LBU/LHU), 0 = sign-extend
//  i_wb_sel       in   2     00 ALU, 01 load, 10 PC+4, 11 reserved
//  i_rd_addr      in   5     destination register
//  i_rd_wren      in   1     instruction writes rd
//  o_rd_addr      out  5     to regfile / forwarding unit
//  o_rd_data      out  32    to regfile / forwarding unit
//  o_rd_wren      out  1     to regfile / forwarding unit
//  o_wb_valid     out  1     instruction retiring this cycle
//  o_wb_pc        out  32    PC of retiring instruction
// BEHAVIOUR
//  - Reset (async, i_reset=1): every register 0 -> o_rd_addr=0, o_rd_data=0, o_rd_wren=0,
//    o_wb_valid=0, o_wb_pc=0 (and o_instret=0). Reset mid-operation drops the in-flight instr.
//  - Latency 1: MEM inputs sampled at posedge N appear on outputs after edge N; regfile commits
//    on the following negedge.
//  - Load format (combinational, before register), lane = i_alu_data[1:0]:
//    byte: i_ld_word[8*lane +: 8]; half: i_ld_word[16*lane[1] +: 16] (lane[0] ignored);
//    word: i_ld_word unchanged (lane ignored); extend per i_ld_unsigned; size 11 -> 0.
//  - WB select: 00 i_alu_data, 01 formatted load, 10 i_pc+4 (mod 2^32, 0xFFFFFFFC -> 0x0),
//    11 -> data 0 and wren forced 0.
//  - Register update priority per posedge: flush > stall > load.
//    flush: valid_q<=0, wren_q<=0, other fields don't-care (held).
//    stall (no flush): all fields hold; a held valid instr keeps o_rd_wren asserted (idempotent).
//    else: capture valid, pc, selected data, rd, wren.
//  - o_rd_wren = valid_q & wren_q & (rd_q != 0); rd=x0 never asserts wren.
//  - o_wb_valid = valid_q & ~i_stall (a stalled instruction retires once, on release).
//  - No handshake back-pressure originates here; stall/flush come from the hazard unit.
// CONFIGURATION
//  WB_INSTRET_EN defined: adds port o_instret out INSTRET_W, retired-instruction count;
//    increments by 1 on each posedge where o_wb_valid=1; wraps all-ones -> 0; reset 0.
//    Counter updates regardless of i_flush (flush affects the incoming instruction only).
//  WB_INSTRET_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: assert i_reset mid-stream with valid instr loaded -> all outputs 0 immediately,
//    no regfile write on next negedge.
//  2 ALU op: valid=1, wb_sel=00, alu=0x0000_1234, rd=5, wren=1 -> after 1 posedge
//    o_rd_addr=5, o_rd_data=0x1234, o_rd_wren=1, o_wb_valid=1.
//  3 Loads, ld_word=0x80FF_7F01: LB lane1 -> 0x0000_007F; LB lane3 -> 0xFFFF_FF80;
//    LBU lane2 -> 0x0000_00FF; LH lane2 -> 0xFFFF_80FF; LHU lane0 -> 0x0000_7F01; LW -> 0x80FF_7F01.
//  4 JAL wb_sel=10, pc=0x0000_0100 -> o_rd_data=0x104; pc=0xFFFF_FFFC -> 0x0; rd=0 -> o_rd_wren=0.
//  5 Stall 3 cycles then flush+stall together -> outputs held during stall, o_wb_valid=0
//    while stalled; flush wins -> o_rd_wren=0, o_wb_valid=0 next cycle.
//  6 WB_INSTRET_EN: 10 valid instrs with 2 bubbles + 1 flush -> o_instret=10;
//    preload near all-ones (force) and retire 2 -> wraps to 1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatting and writeback select.
// Optional retired-instruction counter (o_instret) is enabled by defining WB_INSTRET_EN.
module mem_wb_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic [XLEN-1:0] i_ld_word,
    input  logic [1:0]      i_ld_size,
    input  logic            i_ld_unsigned,
    input  logic [1:0]      i_wb_sel,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_rd_wren,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren,
    output logic            o_wb_valid,
    output logic [XLEN-1:0] o_wb_pc
`ifdef WB_INSTRET_EN
   ,output logic [INSTRET_W-1:0] o_instret
`endif
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("mem_wb_stage supports only XLEN=32");
    end
    if (INSTRET_W < 1) begin : g_bad_instret_w
        $error("mem_wb_stage needs INSTRET_W >= 1");
    end

    logic [1:0]      lane;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] wb_data;
    logic            wb_wren;
    logic            valid_q, valid_d;
    logic            wren_q, wren_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [4:0]      rd_q, rd_d;

    assign lane    = i_alu_data[1:0];
    assign ld_byte = 8'(i_ld_word >> {lane, 3'b000});
    assign ld_half = 16'(i_ld_word >> {lane[1], 4'b0000});

    always_comb begin
        ld_fmt = i_ld_size == 2'b00 ? {{24{~i_ld_unsigned & ld_byte[7]}}, ld_byte} :
                 i_ld_size == 2'b01 ? {{16{~i_ld_unsigned & ld_half[15]}}, ld_half} :
                 i_ld_size == 2'b10 ? i_ld_word : '0;
        wb_data = i_wb_sel == 2'b00 ? i_alu_data :
                  i_wb_sel == 2'b01 ? ld_fmt :
                  i_wb_sel == 2'b10 ? i_pc + 32'd4 : '0;
        // reserved select never writes the register file
        wb_wren = i_rd_wren & (i_wb_sel != 2'b11);
    end

    always_comb begin
        valid_d = valid_q;
        wren_d  = wren_q;
        pc_d    = pc_q;
        data_d  = data_q;
        rd_d    = rd_q;
        if (i_flush) begin
            valid_d = 1'b0;
            wren_d  = 1'b0;
        end else if (!i_stall) begin
            valid_d = i_valid;
            wren_d  = wb_wren;
            pc_d    = i_pc;
            data_d  = wb_data;
            rd_d    = i_rd_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            wren_q  <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wren_q  <= wren_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    assign o_rd_addr  = rd_q;
    assign o_rd_data  = data_q;
    assign o_rd_wren  = valid_q & wren_q & (rd_q != 5'd0);
    assign o_wb_valid = valid_q & ~i_stall;
    assign o_wb_pc    = pc_q;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    assign instret_d = o_wb_valid ? instret_q + 1'b1 : instret_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) instret_q <= '0;
        else         instret_q <= instret_d;
    end

    assign o_instret = instret_q;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed-vector self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, valid = 1'b0;
    logic [31:0] pc = '0, alu = '0, word = '0;
    logic [1:0]  size = '0, sel = '0;
    logic        uns = 1'b0, wren = 1'b0;
    logic [4:0]  rd = '0;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data, o_wb_pc;
    logic        o_rd_wren, o_wb_valid;
`ifdef WB_INSTRET_EN
    logic [63:0] o_instret;
`endif
    int n_chk = 0, n_fail = 0;

    mem_wb_stage dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc(pc), .i_alu_data(alu), .i_ld_word(word), .i_ld_size(size),
        .i_ld_unsigned(uns), .i_wb_sel(sel), .i_rd_addr(rd), .i_rd_wren(wren),
        .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren),
        .o_wb_valid(o_wb_valid), .o_wb_pc(o_wb_pc)
`ifdef WB_INSTRET_EN
       ,.o_instret(o_instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0]  ld_lane [6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0]  ld_size [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        ld_uns  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ld_exp  [6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                                 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    int          pat     [15] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 2, 0, 1, 1, 0, 0};

    initial begin
        #1;
        check("rst_addr", o_rd_addr, 0);
        check("rst_data", o_rd_data, 0);
        check("rst_wren", o_rd_wren, 0);
        check("rst_valid", o_wb_valid, 0);
        check("rst_pc", o_wb_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1; sel = 2'b00; alu = 32'h0000_1234; rd = 5'd5; wren = 1'b1; pc = 32'h40;
        step();
        check("alu_addr", o_rd_addr, 5);
        check("alu_data", o_rd_data, 32'h1234);
        check("alu_wren", o_rd_wren, 1);
        check("alu_valid", o_wb_valid, 1);
        check("alu_pc", o_wb_pc, 32'h40);
        word = 32'h80FF_7F01; sel = 2'b01; rd = 5'd3;
        for (int i = 0; i < 6; i++) begin
            alu = 32'h1000 | {30'h0, ld_lane[i]}; size = ld_size[i]; uns = ld_uns[i];
            step();
            check($sformatf("load%0d", i), o_rd_data, ld_exp[i]);
        end
        sel = 2'b10; pc = 32'h100; rd = 5'd1;
        step();
        check("jal_data", o_rd_data, 32'h104);
        pc = 32'hFFFF_FFFC;
        step();
        check("jal_wrap", o_rd_data, 0);
        rd = 5'd0;
        step();
        check("x0_wren", o_rd_wren, 0);
        check("x0_valid", o_wb_valid, 1);
        sel = 2'b11; rd = 5'd2; alu = 32'h55;
        step();
        check("sel11_data", o_rd_data, 0);
        check("sel11_wren", o_rd_wren, 0);
        sel = 2'b00; alu = 32'hAAAA; rd = 5'd7; pc = 32'h200;
        step();
        check("pre_stall_wren", o_rd_wren, 1);
        stall = 1'b1; alu = 32'hBBBB; rd = 5'd8; pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", o_rd_data, 32'hAAAA);
            check("stall_addr", o_rd_addr, 7);
            check("stall_wren", o_rd_wren, 1);
            check("stall_valid", o_wb_valid, 0);
        end
        flush = 1'b1;
        step();
        check("flush_wren", o_rd_wren, 0);
        check("flush_valid", o_wb_valid, 0);
        stall = 1'b0; flush = 1'b0;
        #1 check("flush_rel_valid", o_wb_valid, 0);
        @(negedge clk);
        alu = 32'hCCCC; rd = 5'd9;
        step();
        stall = 1'b1;
        step();
        check("hold_valid", o_wb_valid, 0);
        check("hold_data", o_rd_data, 32'hCCCC);
        stall = 1'b0;
        #1 check("release_valid", o_wb_valid, 1);
        @(negedge clk);
        alu = 32'hDDDD; rd = 5'd4;
        step();
        check("pre_rst_wren", o_rd_wren, 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_addr", o_rd_addr, 0);
        check("mrst_data", o_rd_data, 0);
        check("mrst_wren", o_rd_wren, 0);
        check("mrst_valid", o_wb_valid, 0);
        check("mrst_pc", o_wb_pc, 0);
        @(negedge clk);
        check("mrst_neg_wren", o_rd_wren, 0);
        rst = 1'b0; valid = 1'b0;
`ifdef WB_INSTRET_EN
        check("instret_rst", o_instret, 0);
        for (int i = 0; i < 15; i++) begin
            valid = pat[i] != 0;
            flush = pat[i] == 2;
            step();
        end
        valid = 1'b0; flush = 1'b0;
        check("instret_count", o_instret, 10);
        force dut.instret_q = '1;
        #1 release dut.instret_q;
        check("instret_force", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        valid = 1'b1;
        step();
        step();
        valid = 1'b0;
        step();
        check("instret_wrap", o_instret, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
